// File: rtl/nec_ir_rx.sv
// NEC infrared remote receiver: synchronises the demodulated IR line, measures
// every level in clk cycles and decodes 32-bit frames and repeat codes.
module nec_ir_rx #(
    parameter int UNIT_CYCLES = 28125,
    parameter int EXT_ADDR    = 0,
    parameter int CHECK_CMD   = 1,
    parameter int MAX_UNITS   = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        irda,
    output logic        data_valid,
    output logic [15:0] addr,
    output logic [7:0]  cmd,
    output logic        rep_valid,
    output logic [7:0]  rep_cnt,
    output logic        err,
    output logic        busy
);
    localparam int U     = UNIT_CYCLES;
    localparam int HALF  = U / 2;
    localparam int LIMIT = MAX_UNITS * U;
    localparam int SAT   = LIMIT + 1;
    localparam int CW    = $clog2(SAT) + 1;

    localparam logic [CW-1:0] L1  = CW'(U - HALF);
    localparam logic [CW-1:0] H1  = CW'(U + HALF);
    localparam logic [CW-1:0] L3  = CW'(3 * U - HALF);
    localparam logic [CW-1:0] H3  = CW'(3 * U + HALF);
    localparam logic [CW-1:0] L4  = CW'(4 * U - HALF);
    localparam logic [CW-1:0] H4  = CW'(4 * U + HALF);
    localparam logic [CW-1:0] L8  = CW'(8 * U - HALF);
    localparam logic [CW-1:0] H8  = CW'(8 * U + HALF);
    localparam logic [CW-1:0] L16 = CW'(16 * U - HALF);
    localparam logic [CW-1:0] H16 = CW'(16 * U + HALF);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);
    localparam logic [CW-1:0] CSAT = CW'(SAT);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD_LOW, S_LEAD_HIGH, S_BIT_LOW, S_BIT_HIGH, S_STOP_LOW, S_REP_LOW
    } state_t;

    state_t        r_state;
    logic          r_sync1, r_sync2, r_prev;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_shift;
    logic [4:0]    r_bit_idx;
    logic          r_have, r_dv, r_rv, r_err, r_busy;
    logic [15:0]   r_addr;
    logic [7:0]    r_cmd, r_rep_cnt;

    logic          w_edge, w_fault;
    logic [CW-1:0] w_len;
    logic          w_is1, w_is3, w_is4, w_is8, w_is16;
    logic [7:0]    w_b0, w_b1, w_b2, w_b3;
    logic          w_addr_ok, w_cmd_ok;
    logic [15:0]   w_addr;

    // The counter restarts at the edge, so the level that just ended spans r_cnt+1 cycles.
    assign w_edge = r_sync2 ^ r_prev;
    assign w_len  = r_cnt + 1'b1;
    assign w_is1  = (w_len >= L1)  && (w_len <= H1);
    assign w_is3  = (w_len >= L3)  && (w_len <= H3);
    assign w_is4  = (w_len >= L4)  && (w_len <= H4);
    assign w_is8  = (w_len >= L8)  && (w_len <= H8);
    assign w_is16 = (w_len >= L16) && (w_len <= H16);

    assign w_b0      = r_shift[7:0];
    assign w_b1      = r_shift[15:8];
    assign w_b2      = r_shift[23:16];
    assign w_b3      = r_shift[31:24];
    assign w_addr_ok = (EXT_ADDR != 0) || (w_b1 == ~w_b0);
    assign w_cmd_ok  = (CHECK_CMD == 0) || (w_b3 == ~w_b2);
    assign w_addr    = (EXT_ADDR != 0) ? {w_b1, w_b0} : {8'h00, w_b0};

    always_comb begin
        w_fault = 1'b0;
        if (r_state != S_IDLE && !w_edge && w_len >= LIM) begin
            w_fault = 1'b1;
        end else if (w_edge) begin
            case (r_state)
                S_LEAD_LOW:  w_fault = !w_is16;
                S_LEAD_HIGH: w_fault = !w_is8 && !w_is4;
                S_BIT_LOW:   w_fault = !w_is1;
                S_BIT_HIGH:  w_fault = !w_is1 && !w_is3;
                S_STOP_LOW:  w_fault = !w_is1;
                S_REP_LOW:   w_fault = !w_is1 || !r_have;
                default:     w_fault = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= irda;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_edge)
                r_cnt <= '0;
            else if (r_cnt != CSAT)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_have    <= 1'b0;
            r_dv      <= 1'b0;
            r_rv      <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_addr    <= '0;
            r_cmd     <= '0;
            r_rep_cnt <= '0;
        end else begin
            r_dv  <= 1'b0;
            r_rv  <= 1'b0;
            r_err <= 1'b0;
            if (w_fault) begin
                r_err   <= 1'b1;
                r_have  <= 1'b0;
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else if (w_edge) begin
                case (r_state)
                    S_IDLE: if (!r_sync2) begin
                        r_state <= S_LEAD_LOW;
                        r_busy  <= 1'b1;
                    end
                    S_LEAD_LOW: r_state <= S_LEAD_HIGH;
                    S_LEAD_HIGH: begin
                        r_bit_idx <= '0;
                        r_state   <= w_is8 ? S_BIT_LOW : S_REP_LOW;
                    end
                    S_BIT_LOW: r_state <= S_BIT_HIGH;
                    S_BIT_HIGH: begin
                        r_shift   <= {w_is3, r_shift[31:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
                        r_state   <= (r_bit_idx == 5'd31) ? S_STOP_LOW : S_BIT_LOW;
                    end
                    S_STOP_LOW: begin
                        if (w_addr_ok && w_cmd_ok) begin
                            r_dv      <= 1'b1;
                            r_addr    <= w_addr;
                            r_cmd     <= w_b2;
                            r_have    <= 1'b1;
                            r_rep_cnt <= '0;
                        end else begin
                            r_err <= 1'b1;
                        end
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    S_REP_LOW: begin
                        r_rv <= 1'b1;
                        if (r_rep_cnt != 8'hFF)
                            r_rep_cnt <= r_rep_cnt + 1'b1;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_valid = r_dv;
    assign addr       = r_addr;
    assign cmd        = r_cmd;
    assign rep_valid  = r_rv;
    assign rep_cnt    = r_rep_cnt;
    assign err        = r_err;
    assign busy       = r_busy;
endmodule

// File: doc/nec_ir_rx.md
Name: nec_ir_rx

Overview:
- Parametrised infrared remote receiver; next generation of the single-FSM IR control block.
- Decodes NEC-protocol frames (leader, 32 data bits LSB-first, stop burst) and repeat codes from the demodulated IR receiver line.
- Uses cycle-accurate pulse-width classification and checks the inverted address/command bytes.
- Sits between the board IR input pin and the button/command logic. Delivers address, command, repeat and error events as single-cycle pulses.

Parameters:
- UNIT_CYCLES, 28125: clk cycles per NEC unit (562.5 us at 50 MHz). Must be ≥ 4.
- EXT_ADDR, 0: 1 = 16-bit extended address, no address-inversion check. 0 = 8-bit address with check.
- CHECK_CMD, 1: 1 = frame rejected if byte3 != ~byte2.
- MAX_UNITS, 20: any level held longer than this many units aborts decoding.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- irda  in  1  raw demodulated IR line; idle high, burst = low. Asynchronous to clk.
- data_valid  out  1  one-cycle pulse: good frame decoded.
- addr  out  16  address. Bits [15:8] are 0 when EXT_ADDR=0. Held until the next good frame.
- cmd  out  8  command byte. Held until the next good frame.
- rep_valid  out  1  one-cycle pulse: repeat code accepted.
- rep_cnt  out  8  repeats since last good frame; saturates at 255.
- err  out  1  one-cycle pulse: malformed frame, timeout or inversion mismatch.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (synchronous, clk rising edge, rst=1):
  - state=IDLE; all outputs 0.
  - Synchroniser flops set to 1.
  - have_frame=0; counter=0.
  - rst mid-frame abandons the frame with no err pulse.
- Input path:
  - 2-flop synchroniser on irda, then edge detect against the previous synchronised value.
  - All outputs are registered.
  - A result pulse appears exactly 3 clk after the raw irda edge that completes the decision.
- Counter:
  - Counts clk cycles of the current level and resets to 0 on every edge.
  - Saturates at MAX_UNITS*UNIT_CYCLES + 1.
  - Width is clog2 of that value plus 1.
- Window rule:
  - A level "is N units" iff N*U − U/2 ≤ count ≤ N*U + U/2, with U=UNIT_CYCLES and U/2 truncated.
  - The boundaries are inclusive.
- FSM:
  - IDLE: falling edge → LEAD_LOW.
  - LEAD_LOW: rising edge; 16 units → LEAD_HIGH, else error.
  - LEAD_HIGH: falling edge; 8 units → BIT_LOW with bit index=0; 4 units → REP_LOW; else error.
  - BIT_LOW: rising edge; 1 unit → BIT_HIGH, else error.
  - BIT_HIGH: falling edge; 1 unit shifts in 0, 3 units shifts in 1, else error. Bits are shifted into a 32-bit register LSB-first. Bit index 31 → STOP_LOW, else index+1 → BIT_LOW.
  - STOP_LOW: rising edge; 1 unit → frame check, else error.
  - REP_LOW: rising edge; 1 unit and have_frame=1 → rep_valid pulse and rep_cnt+1 (saturating). 1 unit with have_frame=0 → err. Otherwise error. All cases return to IDLE.
- Frame check (bytes b0..b3 = bits [7:0]..[31:24]):
  - EXT_ADDR=0: requires b1==~b0; addr={8'h00,b0}.
  - EXT_ADDR=1: addr={b1,b0}.
  - CHECK_CMD=1: requires b3==~b2; cmd=b2.
  - Pass: data_valid pulse, addr/cmd updated, have_frame=1, rep_cnt=0.
  - Fail: err pulse; addr/cmd unchanged.
  - Either way, next state is IDLE.
- Error:
  - Triggered by an out-of-window level, or by count reaching MAX_UNITS*U while not in IDLE (timeout).
  - Effect: err pulse for 1 cycle, have_frame=0, state=IDLE.
  - A fault is taken at the offending edge; a timeout fires without waiting for an edge.
  - Timeout while low leaves the FSM in IDLE with the line low. The next falling edge is still required to start a new frame.
- Only one of data_valid/rep_valid/err is asserted in any cycle.

Test Plan (UNIT_CYCLES=16 for sim):
- Frame bytes 00 FF 45 BA with exact widths → data_valid pulse 3 clk after the stop-burst rising edge; addr=0x0000, cmd=0x45, err=0, busy falls the same cycle.
- Same frame, then a repeat code (16 low / 4 high / 1 low) sent ×3 → three rep_valid pulses, rep_cnt=3. A new frame 00 FF 16 E9 → cmd=0x16, rep_cnt=0.
- Leader low of 16*16+8=264 cycles is accepted, and 265 cycles gives an err pulse at the rising edge. A bit-high of 40 cycles (3U−U/2) is decoded as 1.
- Frame 00 FF 45 BB with CHECK_CMD=1 → err pulse, cmd stays 0x45. The same frame with CHECK_CMD=0 → data_valid, cmd=0x45.
- EXT_ADDR=1, bytes 34 12 0C F3 → addr=0x1234, cmd=0x0C.
- Repeat code after reset with no prior frame → err. Line held low 20U mid-frame → err at timeout with no edge. rst asserted at bit 10 → no pulses, busy=0 the next cycle, and the next full frame decodes correctly.
